// File: rtl/dualmem_arb_pkg.sv
// Shared types and constants for the dual-port RAM port arbiter.
// Holds the arbiter state encoding, default widths, and the lock-counter
// width helper.
package dualmem_arb_pkg;

    localparam int unsigned AW_DEF       = 13;
    localparam int unsigned DW_DEF       = 8;
    localparam int unsigned MAX_LOCK_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    // Bits needed to hold a lock count from 0 up to max_lock inclusive.
    function automatic int unsigned lock_cnt_w(input int unsigned max_lock);
        return $clog2(max_lock + 1);
    endfunction

endpackage

// File: rtl/dualmem_arb_rr2.sv
// Two-way pick with eligibility mask.
// Ports:
//   req_i     - raw requests {m1, m0}
//   mask_i    - masters allowed to win this cycle {m1, m0}
//   prefer1_i - tie-break: 1 picks m1, 0 picks m0 when both are eligible
//   gnt_o     - one-hot (or zero) grant {m1, m0}, combinational
module dualmem_arb_rr2 (
    input  logic [1:0] req_i,
    input  logic [1:0] mask_i,
    input  logic       prefer1_i,
    output logic [1:0] gnt_o
);

    logic [1:0] elig_c;

    // Single eligible master wins outright; a tie goes to the preferred one.
    always_comb begin
        elig_c = req_i & mask_i;
        gnt_o  = 2'b00;
        if (elig_c == 2'b11) begin
            gnt_o = prefer1_i ? 2'b10 : 2'b01;
        end else begin
            gnt_o = elig_c;
        end
    end

endmodule

// File: rtl/dualmem_port_arb.sv
// Shares one port of a dual-port RAM between two masters.
// Round-robin tie-break in IDLE, with optional ownership lock bounded by
// MAX_LOCK consecutive grants when the other master is waiting.
// Build option: define DUALMEM_ARB_FIXED_PRIO_EN to make IDLE ties always go
// to m0 (locking and forced release behave the same).
// Ports:
//   clk, rst             - RAM clock, synchronous active-high reset
//   mX_req/lock/we/addr/wdata - master X request (held until mX_gnt)
//   mX_gnt               - combinational accept in the request cycle
//   mX_rvalid/rdata      - read data one cycle after a granted read
//   mem_en/we/addr/din   - RAM port controls, zero when nothing is granted
//   mem_dout             - RAM read data
module dualmem_port_arb
    import dualmem_arb_pkg::*;
#(
    parameter int unsigned AW       = AW_DEF,
    parameter int unsigned DW       = DW_DEF,
    parameter int unsigned MAX_LOCK = MAX_LOCK_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_lock,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_lock,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    localparam int unsigned CW = lock_cnt_w(MAX_LOCK);

    arb_state_t    state_q, state_d;
    logic [CW-1:0] lock_cnt_q, lock_cnt_d;
    logic [CW-1:0] cnt_inc_c;
    logic [1:0]    rvalid_q, rvalid_d;
    logic [1:0]    req_c, mask_c, gnt_c;
    logic          prefer1_c;
    logic          gnt_lock_c;
    logic          other_req_c;

`ifdef DUALMEM_ARB_FIXED_PRIO_EN
    // Set for one cycle after a forced release out of OWN0 so m1 gets its turn.
    logic fr_q, fr_d;
    assign prefer1_c = fr_q;
`else
    logic last_gnt_q, last_gnt_d;
    assign prefer1_c = ~last_gnt_q;
`endif

    assign req_c = {m1_req, m0_req};

    // Which masters may win: both in IDLE, only the owner while locked, none in reset.
    always_comb begin
        mask_c = 2'b00;
        if (!rst) begin
            case (state_q)
                IDLE:    mask_c = 2'b11;
                OWN0:    mask_c = 2'b01;
                OWN1:    mask_c = 2'b10;
                default: mask_c = 2'b00;
            endcase
        end
    end

    dualmem_arb_rr2 u_rr2 (
        .req_i     (req_c),
        .mask_i    (mask_c),
        .prefer1_i (prefer1_c),
        .gnt_o     (gnt_c)
    );

    // Next-state, lock counter and tie-break history.
    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
`ifdef DUALMEM_ARB_FIXED_PRIO_EN
        fr_d       = 1'b0;
`else
        last_gnt_d = last_gnt_q;
        if (gnt_c[0]) last_gnt_d = 1'b0;
        if (gnt_c[1]) last_gnt_d = 1'b1;
`endif
        gnt_lock_c  = gnt_c[1] ? m1_lock : m0_lock;
        other_req_c = (state_q == OWN0) ? m1_req : m0_req;
        // Saturating increment: count holds at MAX_LOCK while nobody else waits.
        cnt_inc_c   = (lock_cnt_q >= CW'(MAX_LOCK)) ? CW'(MAX_LOCK)
                                                    : lock_cnt_q + CW'(1);
        rvalid_d    = {gnt_c[1] & ~m1_we, gnt_c[0] & ~m0_we};

        case (state_q)
            IDLE: begin
                if ((|gnt_c) && gnt_lock_c) begin
                    state_d    = gnt_c[1] ? OWN1 : OWN0;
                    lock_cnt_d = CW'(1);
                end
            end
            OWN0, OWN1: begin
                if (!(|gnt_c) || !gnt_lock_c) begin
                    // Owner dropped its request or ended the burst.
                    state_d    = IDLE;
                    lock_cnt_d = '0;
                end else if ((cnt_inc_c == CW'(MAX_LOCK)) && other_req_c) begin
                    state_d    = IDLE;
                    lock_cnt_d = '0;
`ifdef DUALMEM_ARB_FIXED_PRIO_EN
                    fr_d       = (state_q == OWN0);
`endif
                end else begin
                    lock_cnt_d = cnt_inc_c;
                end
            end
            default: begin
                state_d    = IDLE;
                lock_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            lock_cnt_q <= '0;
            rvalid_q   <= 2'b00;
`ifdef DUALMEM_ARB_FIXED_PRIO_EN
            fr_q       <= 1'b0;
`else
            last_gnt_q <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            rvalid_q   <= rvalid_d;
`ifdef DUALMEM_ARB_FIXED_PRIO_EN
            fr_q       <= fr_d;
`else
            last_gnt_q <= last_gnt_d;
`endif
        end
    end

    // RAM port mux from the granted master.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        if (gnt_c[0]) begin
            mem_we   = m0_we;
            mem_addr = m0_addr;
            mem_din  = m0_wdata;
        end else if (gnt_c[1]) begin
            mem_we   = m1_we;
            mem_addr = m1_addr;
            mem_din  = m1_wdata;
        end
    end

    assign mem_en    = |gnt_c;
    assign m0_gnt    = gnt_c[0];
    assign m1_gnt    = gnt_c[1];
    assign m0_rvalid = rvalid_q[0];
    assign m1_rvalid = rvalid_q[1];
    assign m0_rdata  = rvalid_q[0] ? mem_dout : '0;
    assign m1_rdata  = rvalid_q[1] ? mem_dout : '0;

endmodule

// File: tb/tb_dualmem_port_arb.sv
// Directed bench for dualmem_port_arb with a 1-cycle-latency RAM model,
// MAX_LOCK overridden to 4.
module tb_dualmem_port_arb;

    localparam int unsigned AW = 13;
    localparam int unsigned DW = 8;

    logic          clk;
    logic          rst;
    logic          m0_req, m0_lock, m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_gnt, m0_rvalid;
    logic [DW-1:0] m0_rdata;
    logic          m1_req, m1_lock, m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_gnt, m1_rvalid;
    logic [DW-1:0] m1_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    int n_tests;
    int n_fail;

    logic [DW-1:0] ram [0:(1<<AW)-1];

    dualmem_port_arb #(.AW(AW), .DW(DW), .MAX_LOCK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (m0_req),
        .m0_lock   (m0_lock),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_lock   (m1_lock),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-first synchronous RAM, 1-cycle read latency.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_din;
            mem_dout <= ram[mem_addr];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        m0_req = 1'b0; m0_lock = 1'b0; m0_we = 1'b0;
        m1_req = 1'b0; m1_lock = 1'b0; m1_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m0_req = 1'b1; m1_req = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_tests++;
            if ({m0_gnt, m1_gnt, mem_en} !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_gnt cyc%0d got %b exp 000", k, {m0_gnt, m1_gnt, mem_en});
            end
            step();
        end
        rst = 1'b0;
        idle_all();
        @(negedge clk);
        n_tests++;
        if ({m0_rvalid, m1_rvalid, m0_rdata, m1_rdata} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_rvalid got %b%b %h %h exp 0", m0_rvalid, m1_rvalid, m0_rdata, m1_rdata);
        end
        step();
    endtask

    task automatic test_write();
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 13'h0010; m0_wdata = 8'hA5;
        @(negedge clk);
        n_tests++;
        if ({m0_gnt, m1_gnt, mem_en, mem_we} !== 4'b1011) begin
            n_fail++;
            $display("FAIL write_ctl got %b exp 1011", {m0_gnt, m1_gnt, mem_en, mem_we});
        end
        n_tests++;
        if (mem_addr !== 13'h0010 || mem_din !== 8'hA5) begin
            n_fail++;
            $display("FAIL write_bus got addr %h din %h exp 0010 a5", mem_addr, mem_din);
        end
        step();
        idle_all();
        @(negedge clk);
        n_tests++;
        if ({m0_rvalid, m1_rvalid, mem_en} !== 3'b000) begin
            n_fail++;
            $display("FAIL write_norvalid got %b exp 000", {m0_rvalid, m1_rvalid, mem_en});
        end
        step();
    endtask

    task automatic test_read();
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 13'h0010;
        @(negedge clk);
        n_tests++;
        if ({m0_gnt, m1_gnt, mem_en, mem_we} !== 4'b0110 || mem_addr !== 13'h0010) begin
            n_fail++;
            $display("FAIL read_gnt got %b addr %h exp 0110 0010", {m0_gnt, m1_gnt, mem_en, mem_we}, mem_addr);
        end
        step();
        idle_all();
        @(negedge clk);
        n_tests++;
        if ({m0_rvalid, m1_rvalid} !== 2'b01 || m1_rdata !== 8'hA5 || m0_rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL read_data got v %b m1 %h m0 %h exp 01 a5 00", {m0_rvalid, m1_rvalid}, m1_rdata, m0_rdata);
        end
        step();
        @(negedge clk);
        n_tests++;
        if (m1_rvalid !== 1'b0 || m1_rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL read_clear got %b %h exp 0 00", m1_rvalid, m1_rdata);
        end
        step();
    endtask

    task automatic test_alternate();
        logic exp0;
        logic prev0;
        prev0 = 1'b0;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 13'h0010;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 13'h0011;
        for (int k = 0; k < 6; k++) begin
`ifdef DUALMEM_ARB_FIXED_PRIO_EN
            exp0 = 1'b1;
`else
            exp0 = (k % 2 == 0);
`endif
            @(negedge clk);
            n_tests++;
            if ({m0_gnt, m1_gnt} !== {exp0, ~exp0}) begin
                n_fail++;
                $display("FAIL alt_gnt cyc%0d got %b exp %b", k, {m0_gnt, m1_gnt}, {exp0, ~exp0});
            end
            if (k > 0) begin
                n_tests++;
                if ({m0_rvalid, m1_rvalid} !== {prev0, ~prev0} ||
                    m0_rdata !== (prev0 ? 8'hA5 : 8'h00) ||
                    m1_rdata !== (prev0 ? 8'h00 : 8'h3C)) begin
                    n_fail++;
                    $display("FAIL alt_rdata cyc%0d got %b %h %h", k, {m0_rvalid, m1_rvalid}, m0_rdata, m1_rdata);
                end
            end
            prev0 = exp0;
            step();
        end
        idle_all();
        step();
    endtask

    task automatic test_lock_burst();
        m0_req = 1'b1; m0_lock = 1'b1; m0_we = 1'b0; m0_addr = 13'h0010;
        m1_req = 1'b1; m1_lock = 1'b0; m1_we = 1'b0; m1_addr = 13'h0011;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_tests++;
            if ({m0_gnt, m1_gnt} !== ((k < 4) ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL lock_burst cyc%0d got %b exp %b", k, {m0_gnt, m1_gnt}, (k < 4) ? 2'b10 : 2'b01);
            end
            step();
        end
        idle_all();
        step();
    endtask

    task automatic test_saturate();
        m0_req = 1'b1; m0_lock = 1'b1; m0_we = 1'b0; m0_addr = 13'h0010;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n_tests++;
            if ({m0_gnt, m1_gnt} !== 2'b10) begin
                n_fail++;
                $display("FAIL sat_hold cyc%0d got %b exp 10", k, {m0_gnt, m1_gnt});
            end
            step();
        end
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 13'h0011;
        @(negedge clk);
        n_tests++;
        if ({m0_gnt, m1_gnt} !== 2'b10) begin
            n_fail++;
            $display("FAIL sat_release got %b exp 10", {m0_gnt, m1_gnt});
        end
        step();
        @(negedge clk);
        n_tests++;
        if ({m0_gnt, m1_gnt} !== 2'b01) begin
            n_fail++;
            $display("FAIL sat_handover got %b exp 01", {m0_gnt, m1_gnt});
        end
        step();
        idle_all();
        step();
    endtask

    task automatic test_owner_drop();
        m0_req = 1'b1; m0_lock = 1'b1; m0_we = 1'b0; m0_addr = 13'h0010;
        @(negedge clk);
        n_tests++;
        if ({m0_gnt, m1_gnt} !== 2'b10) begin
            n_fail++;
            $display("FAIL drop_lock got %b exp 10", {m0_gnt, m1_gnt});
        end
        step();
        m0_req = 1'b0; m0_lock = 1'b0;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 13'h0011;
        @(negedge clk);
        n_tests++;
        if ({m0_gnt, m1_gnt, mem_en} !== 3'b000) begin
            n_fail++;
            $display("FAIL drop_held got %b exp 000", {m0_gnt, m1_gnt, mem_en});
        end
        step();
        @(negedge clk);
        n_tests++;
        if ({m0_gnt, m1_gnt} !== 2'b01) begin
            n_fail++;
            $display("FAIL drop_next got %b exp 01", {m0_gnt, m1_gnt});
        end
        step();
        idle_all();
        step();
    endtask

    task automatic test_reset_mid();
        m1_req = 1'b1; m1_lock = 1'b1; m1_we = 1'b0; m1_addr = 13'h0011;
        @(negedge clk);
        n_tests++;
        if ({m0_gnt, m1_gnt} !== 2'b01) begin
            n_fail++;
            $display("FAIL rmid_own got %b exp 01", {m0_gnt, m1_gnt});
        end
        step();
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({m0_gnt, m1_gnt, mem_en} !== 3'b000) begin
            n_fail++;
            $display("FAIL rmid_gnt got %b exp 000", {m0_gnt, m1_gnt, mem_en});
        end
        step();
        rst = 1'b0;
        m1_lock = 1'b0;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 13'h0010;
        @(negedge clk);
        n_tests++;
        if (m1_rvalid !== 1'b0 || m1_rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL rmid_rvalid got %b %h exp 0 00", m1_rvalid, m1_rdata);
        end
        n_tests++;
        if ({m0_gnt, m1_gnt} !== 2'b10) begin
            n_fail++;
            $display("FAIL rmid_tie got %b exp 10", {m0_gnt, m1_gnt});
        end
        step();
        idle_all();
        step();
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b1;
        mem_dout = '0;
        m0_addr  = '0; m0_wdata = '0;
        m1_addr  = '0; m1_wdata = '0;
        idle_all();
        ram[13'h0011] = 8'h3C;
        #1;
        test_reset();
        test_write();
        test_read();
        test_alternate();
        test_lock_burst();
        test_saturate();
        test_owner_drop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
